// File: rtl/tx_link_sched_pkg.sv
// Shared types and constants for the transmit link scheduler.
// Contents:
//   FLOW_ID_W / FLOW_SEQ_NUM_W / TX_CNT_W : widths of the engine head fields
//   FLOW_ID_NONE / FLOW_SEQ_NONE          : "no entry" marker values
//   TXS_OUT_W                             : width of one captured head entry
//   txs_state_e                           : scheduler FSM encoding
//   txs_head_t                            : packed head entry (fid, seq, tx_id)
//   clogb2()                              : ceiling log2 for index widths
package tx_link_sched_pkg;

    localparam int FLOW_ID_W      = 8;
    localparam int FLOW_SEQ_NUM_W = 16;
    localparam int TX_CNT_W       = 8;

    localparam logic [FLOW_ID_W-1:0]      FLOW_ID_NONE  = '1;
    localparam logic [FLOW_SEQ_NUM_W-1:0] FLOW_SEQ_NONE = '1;

    localparam int TXS_OUT_W = FLOW_ID_W + FLOW_SEQ_NUM_W + TX_CNT_W;

    typedef enum logic [1:0] {
        TXS_IDLE  = 2'd0,
        TXS_SERVE = 2'd1,
        TXS_GAP   = 2'd2
    } txs_state_e;

    typedef struct packed {
        logic [FLOW_ID_W-1:0]      fid;
        logic [FLOW_SEQ_NUM_W-1:0] seq;
        logic [TX_CNT_W-1:0]       tx_id;
    } txs_head_t;

    function automatic int clogb2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/tx_link_sched_rr_next_sel.sv
// Wrapping priority finder for the round-robin pointer.
// Ports:
//   req   : request vector, one bit per engine
//   base  : starting index
//   incl  : 1 = search at or after base, 0 = strictly after base
//   idx   : index of the first request found
//   found : at least one request matched
// With incl=0 the search still wraps all the way back to base itself as the
// last candidate, so a lone requester can be re-selected after its turn.
module rr_next_sel
    import tx_link_sched_pkg::*;
#(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] base,
    input  logic             incl,
    output logic [IDX_W-1:0] idx,
    output logic             found
);

    function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] a, input int k);
        return a + IDX_W'(k);
    endfunction

    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!found && req[wrap_add(base, incl ? k : k + 1)]) begin
                idx   = wrap_add(base, incl ? k : k + 1);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/tx_link_sched.sv
// Weighted round-robin scheduler sharing one MAC link between N_ENG engines.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   eng_val_in        : per-engine head valid
//   eng_fid_in/seq/tx : packed head fields, engine 0 in the LSBs
//   eng_pop_out       : one-hot pop, combinational in the grant cycle
//   cfg_we/addr/data  : addr 0..N_ENG-1 = weight, addr N_ENG = gap, others ignored
//   link_rdy          : MAC accepts the output entry this cycle
//   out_val/eng/fid/seq/tx_id : single-entry output register toward the MAC
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | no engine being served; grants first eligible at/after ptr
// SERVE | serving ptr until its deficit is spent or it goes ineligible
// GAP   | pacing after a grant; gap_cnt counts down, no grants
module tx_link_sched
    import tx_link_sched_pkg::*;
#(
    parameter int N_ENG    = 4,
    parameter int WEIGHT_W = 8,
    parameter int GAP_W    = 8,
    localparam int IDX_W   = clogb2(N_ENG)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [N_ENG-1:0]               eng_val_in,
    input  logic [N_ENG*FLOW_ID_W-1:0]      eng_fid_in,
    input  logic [N_ENG*FLOW_SEQ_NUM_W-1:0] eng_seq_in,
    input  logic [N_ENG*TX_CNT_W-1:0]       eng_tx_id_in,
    output logic [N_ENG-1:0]               eng_pop_out,
    input  logic                           cfg_we,
    input  logic [IDX_W:0]                 cfg_addr,
    input  logic [WEIGHT_W-1:0]            cfg_data,
    input  logic                           link_rdy,
    output logic                           out_val,
    output logic [IDX_W-1:0]               out_eng,
    output logic [FLOW_ID_W-1:0]           out_fid,
    output logic [FLOW_SEQ_NUM_W-1:0]      out_seq,
    output logic [TX_CNT_W-1:0]            out_tx_id
);

    logic [WEIGHT_W-1:0] weight [N_ENG];
    logic [GAP_W-1:0]    gap_reg;
    logic [GAP_W-1:0]    gap_cnt, gap_nxt;
    logic [IDX_W-1:0]    ptr, ptr_nxt;
    logic [WEIGHT_W-1:0] deficit, def_nxt;
    txs_state_e          state, state_nxt;

    logic [N_ENG-1:0]    eligible;
    logic                can_issue;
    logic [IDX_W-1:0]    at_idx, nxt_idx, cur_idx;
    logic                at_found, nxt_found;
    logic                grant, issue_step;
    logic [WEIGHT_W-1:0] cur_def, left_def;
    txs_head_t           grant_head, out_head;

    always_comb begin
        for (int i = 0; i < N_ENG; i++) begin
            eligible[i] = eng_val_in[i] && (weight[i] != '0);
        end
    end

    assign can_issue = (!out_val || link_rdy) && (gap_cnt == '0);

    // In IDLE the engine to serve is found on the fly; in SERVE it is ptr.
    assign cur_idx = (state == TXS_IDLE) ? at_idx : ptr;

    rr_next_sel #(.N(N_ENG), .IDX_W(IDX_W)) u_sel_at (
        .req   (eligible),
        .base  (ptr),
        .incl  (1'b1),
        .idx   (at_idx),
        .found (at_found)
    );

    rr_next_sel #(.N(N_ENG), .IDX_W(IDX_W)) u_sel_after (
        .req   (eligible),
        .base  (cur_idx),
        .incl  (1'b0),
        .idx   (nxt_idx),
        .found (nxt_found)
    );

    always_comb begin
        state_nxt  = state;
        ptr_nxt    = ptr;
        def_nxt    = deficit;
        gap_nxt    = (gap_cnt != '0) ? gap_cnt - GAP_W'(1) : '0;
        grant      = 1'b0;
        issue_step = 1'b0;
        cur_def    = deficit;
        left_def   = deficit;

        case (state)
            TXS_IDLE: begin
                if (can_issue && at_found) begin
                    issue_step = 1'b1;
                    grant      = 1'b1;
                    cur_def    = weight[at_idx];
                end
            end
            TXS_SERVE: begin
                if (can_issue) begin
                    issue_step = 1'b1;
                    grant      = eligible[ptr] && (deficit != '0);
                end
            end
            TXS_GAP: begin
                // Leave as the counter reaches zero so the next grant can
                // land in the first cycle gap_cnt reads zero.
                if (gap_cnt <= GAP_W'(1)) begin
                    state_nxt = (deficit != '0) ? TXS_SERVE : TXS_IDLE;
                end
            end
            default: state_nxt = TXS_IDLE;
        endcase

        if (issue_step) begin
            left_def  = grant ? cur_def - WEIGHT_W'(1) : cur_def;
            ptr_nxt   = cur_idx;
            def_nxt   = left_def;
            state_nxt = TXS_SERVE;
            if (!grant || left_def == '0) begin
                if (nxt_found) begin
                    ptr_nxt = nxt_idx;
                    def_nxt = weight[nxt_idx];
                end else begin
                    ptr_nxt   = cur_idx + IDX_W'(1);
                    def_nxt   = '0;
                    state_nxt = TXS_IDLE;
                end
            end
            if (grant && gap_reg != '0) begin
                state_nxt = TXS_GAP;
                gap_nxt   = gap_reg;
            end
        end
    end

    always_comb begin
        grant_head.fid   = eng_fid_in[cur_idx*FLOW_ID_W +: FLOW_ID_W];
        grant_head.seq   = eng_seq_in[cur_idx*FLOW_SEQ_NUM_W +: FLOW_SEQ_NUM_W];
        grant_head.tx_id = eng_tx_id_in[cur_idx*TX_CNT_W +: TX_CNT_W];
    end

    // Pop is suppressed while rst is high so no engine dequeues an entry
    // that the output register is about to drop.
    always_comb begin
        eng_pop_out = '0;
        if (grant && !rst) begin
            eng_pop_out[cur_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= TXS_IDLE;
            ptr     <= '0;
            deficit <= '0;
            gap_cnt <= '0;
        end else begin
            state   <= state_nxt;
            ptr     <= ptr_nxt;
            deficit <= def_nxt;
            gap_cnt <= gap_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_ENG; i++) begin
                weight[i] <= WEIGHT_W'(1);
            end
            gap_reg <= '0;
        end else if (cfg_we) begin
            if (!cfg_addr[IDX_W]) begin
                weight[cfg_addr[IDX_W-1:0]] <= cfg_data;
            end else if (cfg_addr[IDX_W-1:0] == '0) begin
                gap_reg <= GAP_W'(cfg_data);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_val        <= 1'b0;
            out_eng        <= '0;
            out_head.fid   <= FLOW_ID_NONE;
            out_head.seq   <= FLOW_SEQ_NONE;
            out_head.tx_id <= '0;
        end else if (grant) begin
            out_val  <= 1'b1;
            out_eng  <= cur_idx;
            out_head <= grant_head;
        end else if (link_rdy) begin
            out_val <= 1'b0;
        end
    end

    assign out_fid   = out_head.fid;
    assign out_seq   = out_head.seq;
    assign out_tx_id = out_head.tx_id;

endmodule

// File: doc/tx_link_sched.md
Name: tx_link_sched

Overview:
- Weighted round-robin scheduler sharing one physical link between N_ENG transport engine instances.
- Each engine exposes its output-queue head: valid, fid, seq and tx_id.
- The block selects one engine per grant and asserts that engine's pop, which drives the engine's link_avail. It captures the head into a single-entry output register toward the MAC.
- Enforces a programmable minimum inter-grant gap (link pacing) and honours MAC backpressure.

Parameters:
- N_ENG, 4, number of engines sharing the link (power of 2, 2..16).
- WEIGHT_W, 8, width of per-engine weight/deficit counters.
- GAP_W, 8, width of inter-grant gap counter.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- eng_val_in  in  N_ENG  per-engine head valid (engine next_val).
- eng_fid_in  in  N_ENG*`FLOW_ID_W  packed head fids, engine 0 in LSBs.
- eng_seq_in  in  N_ENG*`FLOW_SEQ_NUM_W  packed head seqs.
- eng_tx_id_in  in  N_ENG*`TX_CNT_W  packed head tx ids.
- eng_pop_out  out  N_ENG  one-hot pop, wired to each engine's link_avail.
- cfg_we  in  1  config write strobe.
- cfg_addr  in  clogb2(N_ENG)+1  0..N_ENG-1 = weight[addr]; N_ENG = gap register.
- cfg_data  in  WEIGHT_W (GAP_W used for gap)  config value.
- link_rdy  in  1  MAC accepts out entry this cycle.
- out_val  out  1  output register holds an entry.
- out_eng  out  clogb2(N_ENG)  source engine index.
- out_fid  out  `FLOW_ID_W  fid.
- out_seq  out  `FLOW_SEQ_NUM_W  seq.
- out_tx_id  out  `TX_CNT_W  tx id.

Behaviour:
- Reset values:
  - eng_pop_out=0, out_val=0, out_eng=0.
  - out_fid=`FLOW_ID_NONE, out_seq=`FLOW_SEQ_NONE, out_tx_id=0.
  - All weights=1, gap=0, rr pointer=0, deficit=0, FSM=IDLE.
- eligible[i] = eng_val_in[i] & weight[i]!=0. A weight of 0 disables engine i.
- can_issue = (!out_val | link_rdy) & gap_cnt==0.
- FSM states:
  - IDLE: when can_issue and any eligible, pick the first eligible engine at or after ptr (wrapping), set ptr to it, load deficit=weight[ptr], go to SERVE with the grant issued the same cycle.
  - SERVE: each cycle with can_issue, grant ptr if eligible[ptr] & deficit!=0, then decrement deficit.
    - If deficit reaches 0 after this grant, or ptr is not eligible, advance ptr to the next eligible engine strictly after ptr (wrapping) and reload its deficit.
    - If none are eligible, return to IDLE with ptr = old ptr+1 (mod N_ENG).
  - GAP: entered after a grant when gap!=0. gap_cnt loads gap and decrements each cycle; no grants while nonzero. On zero, go to SERVE if deficit!=0, else IDLE.
- Grant in cycle t:
  - eng_pop_out[ptr]=1 combinationally in cycle t; at most one bit set, and never set while !can_issue.
  - Head fields of ptr are sampled in cycle t; out_* and out_val=1 are valid at t+1. Latency from eligible to out_val is 1 cycle.
- Output register: holds while out_val & !link_rdy. Cleared to out_val=0 on link_rdy with no new grant. Back-to-back grant and accept in the same cycle is allowed, giving full throughput when gap=0.
- Engine eng_val_in dropping in the same cycle a grant would occur: no pop to that engine; advance as not eligible.
- cfg write:
  - Takes effect next cycle.
  - Writing the weight of the currently served engine does not alter its live deficit; it applies on next reload.
  - A cfg write coinciding with a grant is legal and does not stall.
  - cfg_addr > N_ENG is ignored.
- Deficit arithmetic is unsigned WEIGHT_W and never underflows.
- rst mid-operation: all state returns to reset values next cycle; any held out entry is dropped. Engines must be reset together.

Decomposition:
- Shared package/header adds:
  - `TXS_IDX_W (clogb2 of N_ENG).
  - State encodings `TXS_IDLE/`TXS_SERVE/`TXS_GAP.
  - `TXS_OUT_W = `FLOW_ID_W+`FLOW_SEQ_NUM_W+`TX_CNT_W.
  - Reuse existing FLOW_ID_NONE/FLOW_SEQ_NONE.
- One sub-module: rr_next_sel — combinational "first set bit at or after/after index, wrapping" finder, returning index and found flag.

Test Plan:
- Weights all 1, gap 0, engines 0..3 continuously valid, link_rdy=1 -> pops cycle 0,1,2,3 go to engines 0,1,2,3 then repeat; out_eng lags pop by 1 cycle.
- Weights {3,1,0,2}, all valid -> grant pattern 0,0,0,1,3,3 repeating; engine 2 is never popped.
- gap=2, only engine 1 valid -> pops on cycles 0,3,6; out_val pulses 1 cycle each.
- Engine 0 valid, link_rdy=0 for 5 cycles after first grant -> exactly one pop; out_* stable for 5 cycles; second pop issues in the cycle link_rdy returns to 1.
- During SERVE of engine 2 with deficit 3, write weight[2]=1; then drop eng_val_in[2] after 1 grant -> ptr moves to engine 3; next reload of engine 2 grants only once.
- Assert rst during an active stream with out_val=1 -> next cycle all outputs at reset values, no pop; after release, scheduling restarts at engine 0.
